// File: rtl/aud_i2c_arb.sv
// aud_i2c_arb: two-client arbiter/sequencer in front of the codec I2C write
// engine. Client 0 is the power-up init sequencer; client 1 is the runtime
// control path. One 16-bit register write is granted at a time. The sequence
// is setup hold, start strobe, wait for the engine busy/idle cycle, ack, then
// an inter-write gap.
//
// Optional build macro: AUD_ARB_TIMEOUT_EN adds a WAIT-state timeout. When a
// transfer times out it is acked with err=1. Without the macro, WAIT holds
// indefinitely and err is tied 0.
//
// Handshake: a client raises reqN with addrN/dataN valid and holds all three
// until ackN pulses for one cycle. The request is sampled only in IDLE, and
// addr/data are latched at the grant. If reqN is still high in the cycle
// after ackN, it is taken as a fresh request and is arbitrated after the gap.
module aud_i2c_arb #(
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned START_CYC = 5,
  parameter int unsigned GAP_CYC   = 50
`ifdef AUD_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 2000000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req0,
  input  logic [6:0] addr0,
  input  logic [8:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [6:0] addr1,
  input  logic [8:0] data1,
  output logic       ack1,
  output logic [7:0] i2c_addr1,
  output logic [6:0] i2c_addr2,
  output logic [8:0] i2c_data,
  output logic       i2c_start,
  input  logic       i2c_idle,
  output logic       busy,
  output logic       owner,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // One shared down-counter serves setup, start and gap; size it for the largest.
  localparam int unsigned CNT_MAX0 = (SETUP_CYC > START_CYC) ? SETUP_CYC : START_CYC;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > GAP_CYC) ? CNT_MAX0 : GAP_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             seen;      // engine has been observed busy in this WAIT
  logic             rr_last;   // client served most recently
  logic             gnt_valid;
  logic             gnt_sel;

`ifdef AUD_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wcnt;
`else
  assign err = 1'b0;
`endif

  assign i2c_addr1 = DEV_ADDR;
  assign state_dbg = state;

  // Round-robin pick: a lone request wins, and a tie goes to the client not served last.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_sel   = 1'b0;
    if (req0 && req1) gnt_sel = ~rr_last;
    else if (req1)    gnt_sel = 1'b1;
  end

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      seen      <= 1'b0;
      rr_last   <= 1'b1;
      owner     <= 1'b0;
      i2c_start <= 1'b0;
      i2c_addr2 <= '0;
      i2c_data  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
`ifdef AUD_ARB_TIMEOUT_EN
      err       <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
`ifdef AUD_ARB_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_sel;
            rr_last   <= gnt_sel;
            i2c_addr2 <= gnt_sel ? addr1 : addr0;
            i2c_data  <= gnt_sel ? data1 : data0;
            busy      <= 1'b1;
            count     <= CNT_W'(SETUP_CYC - 1);
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (count == '0) begin
            count     <= CNT_W'(START_CYC - 1);
            i2c_start <= 1'b1;
            state     <= S_START;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_START: begin
          if (count == '0) begin
            i2c_start <= 1'b0;
            seen      <= 1'b0;
`ifdef AUD_ARB_TIMEOUT_EN
            wcnt      <= '0;
`endif
            state     <= S_WAIT;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_WAIT: begin
          // Idle is trusted only after the engine has first shown busy.
          if (seen && i2c_idle) begin
            ack0  <= ~owner;
            ack1  <= owner;
            state <= S_ACK;
          end
`ifdef AUD_ARB_TIMEOUT_EN
          else if (wcnt == TO_W'(TIMEOUT_CYC - 1)) begin
            ack0  <= ~owner;
            ack1  <= owner;
            err   <= 1'b1;
            state <= S_ACK;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
          if (!i2c_idle) seen <= 1'b1;
        end
        S_ACK: begin
          count <= CNT_W'(GAP_CYC - 1);
          state <= S_GAP;
        end
        S_GAP: begin
          if (count == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          i2c_start <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
